// File: rtl/addsub_pkg.sv
// Shared types for the nibble-serial add/subtract controller.
// Slice width and FSM state encoding.
package addsub_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_addsub.sv
// One 4-bit add/subtract slice: four chained full adders.
// B is inverted when subtracting; the caller supplies the carry-in.
module nibble_addsub
    import addsub_pkg::*;
(
    input  logic [SLICE_W-1:0] a4,
    input  logic [SLICE_W-1:0] b4,
    input  logic               cin,
    input  logic               subtract,
    output logic [SLICE_W-1:0] s4,
    output logic               cout
);

    logic [SLICE_W-1:0] bx;
    logic [SLICE_W:0]   c;

    assign bx   = b4 ^ {SLICE_W{subtract}};
    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s4[i]  = a4[i] ^ bx[i] ^ c[i];
        assign c[i+1] = (a4[i] & bx[i]) | (c[i] & (a4[i] ^ bx[i]));
    end

    assign cout = c[SLICE_W];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Nibble-serial add/subtract controller, LSB nibble first.
// Operands latched on accept; result held until handshake.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   subtract,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   carry,
    output logic                   overflow
);

    localparam int W  = SLICE_W * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e             state_q;
    logic [W-1:0]       a_q, b_q, sum_q;
    logic               sub_q, cy_q;
    logic               carry_q, ovf_q;
    logic               in_ready_q, out_valid_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last;
    logic [SLICE_W-1:0] a_nib, b_nib, s4;
    logic               cout;

    always_comb begin
        a_nib = a_q[int'(cnt_q)*SLICE_W +: SLICE_W];
        b_nib = b_q[int'(cnt_q)*SLICE_W +: SLICE_W];
        last  = (cnt_q == CW'(NIBBLES - 1));
        cnt_d = last ? cnt_q : cnt_q + CW'(1);
    end

    nibble_addsub u_slice (
        .a4       (a_nib),
        .b4       (b_nib),
        .cin      (cy_q),
        .subtract (sub_q),
        .s4       (s4),
        .cout     (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            cy_q        <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        sub_q      <= subtract;
                        cy_q       <= subtract;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[int'(cnt_q)*SLICE_W +: SLICE_W] <= s4;
                    cy_q  <= cout;
                    cnt_q <= cnt_d;
                    if (last) begin
                        carry_q     <= cout;
                        // sign of result is the top bit of the final slice
                        ovf_q       <= (a_q[W-1] == (b_q[W-1] ^ sub_q))
                                     && (s4[SLICE_W-1] != a_q[W-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl (NIBBLES=4).
// Directed corner cases, backpressure, reset abandon, random traffic.
module tb_serial_addsub_ctrl;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         subtract;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   rnd_en = 0;

    serial_addsub_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .subtract  (subtract),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    function automatic exp_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic sub);
        exp_t e;
        int ua, ub, sa, sb, r, sr;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sb = int'($signed(y));
        if (sub) begin
            r   = ua - ub;
            sr  = sa - sb;
            e.c = (ua >= ub);
        end else begin
            r   = ua + ub;
            sr  = sa + sb;
            e.c = (r >= 65536);
        end
        e.s = W'(r);
        e.v = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(sum), 32'hdead);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("carry", 32'(carry), 32'(e.c));
                chk("overflow", 32'(overflow), 32'(e.v));
            end
        end
        if (!rst && out_valid && in_ready)
            chk("ready_valid_excl", 32'(1), 32'(0));
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accept edge
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sub);
        bit ok = 0;
        a        = x;
        b        = y;
        subtract = sub;
        in_valid = 1'b1;
        exp_q.push_back(model(x, y, sub));
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 32'(0), 32'(1));
            void'(exp_q.pop_back());
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'(0));
            exp_q.delete();
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] t[5];
        t[0] = 16'h0000;
        t[1] = 16'hFFFF;
        t[2] = 16'h7FFF;
        t[3] = 16'h8000;
        t[4] = W'($urandom);
        return ($urandom_range(0, 3) == 0) ? t[$urandom_range(0, 3)] : t[4];
    endfunction

    initial begin
        int lat;
        logic [W-1:0] hold_s;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        subtract  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_carry", 32'(carry), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(16'h1234, 16'h0FFF, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(4));
        drain();

        send(16'h0005, 16'h0007, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h0001, 1'b1);
        drain();

        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        hold_s = sum;
        chk("bp_sum_first", 32'(hold_s), 32'h3333);
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            a        = W'($urandom);
            b        = W'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'(1));
            chk("bp_in_ready", 32'(in_ready), 32'(0));
            chk("bp_sum_stable", 32'(sum), 32'(hold_s));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(out_valid), 32'(0));
        chk("bp_release_ready", 32'(in_ready), 32'(1));
        drain();

        send(16'h4444, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abandon_out_valid", 32'(out_valid), 32'(0));
        chk("abandon_in_ready", 32'(in_ready), 32'(1));
        chk("abandon_sum", 32'(sum), 32'(0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abandon_no_result", 32'(out_valid), 32'(0));
        end
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0001, 1'b0);
        drain();
        chk("post_rst_sum", 32'(sum), 32'h0002);

        rnd_en = 1;
        for (int i = 0; i < 1000; i++)
            send(pick(), pick(), 1'($urandom_range(0, 1)));
        drain();
        rnd_en = 0;
        #2;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 Clock: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge system clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand request valid.
REQ-006 in_ready  out  1  controller can accept a request.
REQ-007 a  in  W  minuend/augend, unsigned or two's complement.
REQ-008 b  in  W  subtrahend/addend.
REQ-009 subtract  in  1  1 = a-b, 0 = a+b; sampled with the operands.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 sum  out  W  result, modulo 2^W.
REQ-013 carry  out  1  final carry-out; for subtract, 1 = no borrow.
REQ-014 overflow  out  1  signed two's-complement overflow.

Function
REQ-015 The controller SHALL compute through a single 4-bit add/subtract slice, one nibble per clock, LSB nibble first.
REQ-016 States SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE: on in_valid & in_ready at edge k, latch a, b and subtract, preset the carry register to subtract, clear the nibble counter, and enter RUN.
REQ-018 RUN: each edge SHALL write slice nibble i of sum, update the carry register with the slice carry-out, and increment the counter.
REQ-019 Slice i inputs SHALL be a[4i+3:4i], b[4i+3:4i] XOR {4{subtract}}, and the carry register.
REQ-020 After the edge that processes nibble NIBBLES-1 (edge k+NIBBLES), the controller SHALL enter DONE; latency is NIBBLES cycles from accept to out_valid.
REQ-021 carry SHALL be the carry-out of the last nibble.
REQ-022 overflow SHALL be 1 when a[W-1] equals (b[W-1]^subtract) and sum[W-1] differs from a[W-1].
REQ-023 DONE: sum, carry and overflow SHALL be held stable while out_valid & !out_ready.
REQ-024 On out_valid & out_ready, the controller SHALL return to IDLE at that edge.
REQ-025 in_valid outside IDLE SHALL be ignored; no request is queued, and a new request can be accepted one cycle after the result handshake at the earliest.
REQ-026 Operand inputs SHALL not affect an operation in progress; only the latched copies are used.
REQ-027 The counter SHALL be wide enough for NIBBLES-1 and SHALL not wrap within RUN; it is cleared on accept.
REQ-028 sum, carry and overflow SHALL retain the last completed result in IDLE; out_valid qualifies them.

Reset
REQ-029 When rst = 1 at an edge, the controller SHALL enter IDLE with in_ready=1, out_valid=0, sum=0, carry=0, overflow=0, counter=0 and carry register=0.
REQ-030 Reset during RUN or DONE SHALL abandon the operation; no result is presented afterwards.
REQ-031 rst SHALL dominate in_valid and out_ready in the same cycle.

Structure
REQ-032 The state encoding and the slice width constant (4) SHALL live in a shared package, addsub_pkg.
REQ-033 One sub-module, nibble_addsub, SHALL implement the slice: inputs a4, b4, cin, subtract; outputs s4, cout; 4 chained full adders with B XOR subtract.
REQ-034 Only one nibble_addsub instance SHALL exist; the controller holds the registers, counter and FSM.

Verification (NIBBLES=4)
REQ-035 Add 0x1234+0x0FFF, sub=0 -> sum=0x2233, carry=0, overflow=0, out_valid rises exactly 4 cycles after accept.
REQ-036 Subtract 0x0005-0x0007 -> sum=0xFFFE, carry=0 (borrow), overflow=0.
REQ-037 Add 0x7FFF+0x0001 -> sum=0x8000, carry=0, overflow=1; add 0xFFFF+0x0001 -> sum=0x0000, carry=1, overflow=0.
REQ-038 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid/a/b -> result stable, in_ready=0, no accept; out_ready=1 -> IDLE next edge.
REQ-039 rst=1 in the 2nd RUN cycle -> next edge IDLE, out_valid=0, in_ready=1, sum=0; a following request 0x0001+0x0001 -> sum=0x0002.
REQ-040 Random back-to-back requests (1000, with random out_ready stalls) -> every result matches the W-bit add/sub reference model, including carry and overflow.
